rr_mem_arbiter: RTL and testbench
=================================

RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of requesting cache ports (1..8).
REQ-002 SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_read  input  NUM_CH  per-channel line read request.
REQ-007 SHALL have port req_write  input  NUM_CH  per-channel line write request.
REQ-008 SHALL have port req_addr  input  NUM_CH x ADDR_W  per-channel line address.
REQ-009 SHALL have port req_wdata  input  NUM_CH x LINE_W  per-channel write line.
REQ-010 SHALL have port req_resp  output  NUM_CH  one-hot completion pulse.
REQ-011 SHALL have port req_rdata  output  LINE_W  read line, shared by all channels, valid with req_resp.
REQ-012 SHALL have ports mem_read / mem_write  output  1 each  downstream (L2/pmem) command.
REQ-013 SHALL have ports mem_address  output  ADDR_W; mem_wdata  output  LINE_W.
REQ-014 SHALL have ports mem_rdata  input  LINE_W; mem_resp  input  1.
REQ-015 SHALL have port busy  output  1  transaction in flight.
REQ-016 SHALL have port grant_cnt  output  NUM_CH x 32  per-channel completed-grant counters.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-018 IDLE: if any channel requests, SHALL select the first requester at or after rr_ptr (wrapping modulo NUM_CH), latch its id, op, address and wdata, and enter BUSY; otherwise stay in IDLE.
REQ-019 Channel with req_read and req_write both high SHALL be granted as a write; the read is serviced on a later grant.
REQ-020 BUSY: mem_read/mem_write, mem_address and mem_wdata SHALL be driven solely from latched values; input changes during BUSY SHALL be ignored.
REQ-021 BUSY with mem_resp=1: SHALL register mem_rdata, deassert mem_read/mem_write from the next cycle, and enter DONE.
REQ-022 DONE: SHALL pulse req_resp[id] for exactly one cycle with the registered req_rdata, set rr_ptr = (id+1) mod NUM_CH, and return to IDLE.
REQ-023 Latency: request sampled in IDLE at cycle t -> mem command at t+1; mem_resp at cycle r -> req_resp at r+1; minimum 3 cycles per transaction.
REQ-024 mem_resp while in IDLE or DONE SHALL be ignored.
REQ-025 rr_ptr wrap: id = NUM_CH-1 SHALL yield rr_ptr = 0; NUM_CH=1 SHALL degenerate to fixed grant.
REQ-026 busy SHALL be 1 in BUSY and DONE, 0 in IDLE.
REQ-027 req_rdata SHALL hold its last value outside DONE.

Reset
REQ-028 On rst: state IDLE, rr_ptr 0, mem_read/mem_write/req_resp/busy 0, req_rdata/mem_address/mem_wdata 0, grant_cnt 0, all asynchronously.
REQ-029 Reset mid-transaction SHALL abort it with no req_resp emitted; mem command SHALL drop in the reset cycle.

Configuration
REQ-030 Macro ARB_PERF_CNT_EN defined: grant_cnt[i] SHALL increment (wrapping modulo 2^32) in each DONE cycle with id=i.
REQ-031 Macro ARB_PERF_CNT_EN undefined: grant_cnt SHALL be constant 0 and no counter registers SHALL be synthesised.

Structure
REQ-032 Shared package arb_types SHALL hold the state enum (IDLE, BUSY, DONE) and the NUM_CH maximum constant.
REQ-033 Round-robin selection SHALL live in one combinational sub-module rr_picker (inputs request vector and rr_ptr; outputs valid and id).

Verification
REQ-034 NUM_CH=2, ch0 read addr 0x100, mem_resp after 4 cycles, mem_rdata 0xAA..AA -> mem_read cycles 1..5, req_resp[0] at cycle 6 with req_rdata 0xAA..AA.
REQ-035 ch0 and ch1 both read at cycle 0, rr_ptr 0 -> ch0 served first, ch1 served second; repeat -> ch1 then ch0.
REQ-036 ch1 read+write simultaneously, addr 0x240 -> mem_write first with req_wdata[1], later mem_read at 0x240.
REQ-037 rst asserted in BUSY -> mem_read 0 same cycle, no req_resp, next request is granted to ch0.
REQ-038 NUM_CH=4, all requesting continuously, 8 grants -> order 0,1,2,3,0,1,2,3; with ARB_PERF_CNT_EN grant_cnt = 2 each, without = 0.

Source files
------------

// File: rtl/rr_mem_arbiter_pkg.sv
// Shared types for the round-robin memory arbiter: FSM state encoding and
// the largest supported channel count.
package arb_types;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_mem_arbiter_picker.sv
// Combinational round-robin picker: returns the first requester at or after
// i_ptr, wrapping modulo NUM_CH.
module rr_picker
  import arb_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [ID_W-1:0]   i_ptr,
  output logic              o_valid,
  output logic [ID_W-1:0]   o_id
);

  logic [2*NUM_CH-1:0] w_shift;
  logic [NUM_CH-1:0]   w_rot;
  logic [ID_W-1:0]     w_off;
  logic [ID_W:0]       w_sum;

  // Rotating the doubled vector puts the channel at i_ptr into bit 0.
  assign w_shift = {i_req, i_req} >> i_ptr;
  assign w_rot   = w_shift[NUM_CH-1:0];
  assign o_valid = |w_rot;

  always_comb begin
    w_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ID_W'(k);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_id  = (w_sum >= (ID_W+1)'(NUM_CH)) ? ID_W'(w_sum - (ID_W+1)'(NUM_CH))
                                              : w_sum[ID_W-1:0];

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH cache-line ports onto one memory port.
// Define ARB_PERF_CNT_EN to build the per-channel completed-grant counters.
module rr_mem_arbiter
  import arb_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic [LINE_W-1:0]        req_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  output logic                     busy,
  output logic [NUM_CH*32-1:0]     grant_cnt
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("rr_mem_arbiter: NUM_CH out of range");
  end

  arb_state_e        r_state;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_req_rdata;
  logic [NUM_CH-1:0] r_req_resp;
  logic              r_busy;

  logic [NUM_CH-1:0] w_req_any;
  logic              w_pick_valid;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_pick_write;
  logic [ID_W-1:0]   w_next_ptr;

  assign w_req_any    = req_read | req_write;
  assign w_pick_write = req_write[w_pick_id];
  assign w_next_ptr   = (r_id == ID_W'(NUM_CH - 1)) ? '0 : r_id + 1'b1;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_picker (
    .i_req   (w_req_any),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_id          <= '0;
      r_rr_ptr      <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_req_rdata   <= '0;
      r_req_resp    <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A channel asking for both is granted the write; its read stays pending.
          if (w_pick_valid) begin
            r_id          <= w_pick_id;
            r_mem_write   <= w_pick_write;
            r_mem_read    <= ~w_pick_write;
            r_mem_address <= req_addr[w_pick_id*ADDR_W +: ADDR_W];
            r_mem_wdata   <= req_wdata[w_pick_id*LINE_W +: LINE_W];
            r_busy        <= 1'b1;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            r_req_rdata       <= mem_rdata;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_req_resp        <= '0;
            r_req_resp[r_id]  <= 1'b1;
            r_state           <= DONE;
          end
        end
        DONE: begin
          r_req_resp <= '0;
          r_rr_ptr   <= w_next_ptr;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (r_state == DONE && r_id == ID_W'(gi)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign grant_cnt[gi*32 +: 32] = r_cnt;
  end
`else
  assign grant_cnt = '0;
`endif

  assign req_resp    = r_req_resp;
  assign req_rdata   = r_req_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed bench for rr_mem_arbiter: a 2-channel instance for protocol and
// ordering, a 4-channel instance for continuous round-robin rotation.
module tb_rr_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
`ifdef ARB_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic [1:0]      a_rd, a_wr, a_resp;
  logic [2*AW-1:0] a_addr;
  logic [2*LW-1:0] a_wdata;
  logic [LW-1:0]   a_rdata, a_mem_wdata, a_mem_rdata;
  logic            a_mem_read, a_mem_write, a_mem_resp, a_busy;
  logic [AW-1:0]   a_mem_address;
  logic [63:0]     a_cnt;

  logic [3:0]      b_rd, b_wr, b_resp;
  logic [4*AW-1:0] b_addr;
  logic [4*LW-1:0] b_wdata;
  logic [LW-1:0]   b_rdata, b_mem_wdata, b_mem_rdata;
  logic            b_mem_read, b_mem_write, b_mem_resp, b_busy;
  logic [AW-1:0]   b_mem_address;
  logic [127:0]    b_cnt;

  rr_mem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_resp(a_resp), .req_rdata(a_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp),
    .busy(a_busy), .grant_cnt(a_cnt)
  );

  rr_mem_arbiter #(.NUM_CH(4), .LINE_W(LW), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_resp(b_resp), .req_rdata(b_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
    .busy(b_busy), .grant_cnt(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 2-channel transaction: the request must already be driven; lat is the
  // number of BUSY cycles before mem_resp is raised.
  task automatic txn2(input int ch, input logic wr, input logic [AW-1:0] addr,
                      input logic [LW-1:0] wd, input logic [LW-1:0] rd, input int lat);
    logic [2*AW-1:0] saved;
    tick();
    chk("grant_mem_read", a_mem_read, !wr);
    chk("grant_mem_write", a_mem_write, wr);
    chk("grant_addr", a_mem_address, addr);
    if (wr) chk("grant_wdata", a_mem_wdata, wd);
    chk("grant_busy", a_busy, 1);
    saved  = a_addr;
    a_addr = ~saved;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("hold_cmd", {a_mem_read, a_mem_write}, wr ? 2'b01 : 2'b10);
      chk("hold_addr", a_mem_address, addr);
      chk("hold_no_resp", a_resp, 0);
    end
    a_addr      = saved;
    a_mem_rdata = rd;
    a_mem_resp  = 1'b1;
    tick();
    a_mem_rdata = ~rd;
    chk("done_resp", a_resp, 2'b01 << ch);
    chk("done_rdata", a_rdata, rd);
    chk("done_cmd_off", {a_mem_read, a_mem_write}, 0);
    chk("done_busy", a_busy, 1);
    tick();
    a_mem_resp = 1'b0;
    chk("idle_resp_clr", a_resp, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_rdata_hold", a_rdata, rd);
    $display("txn ch%0d %s addr=%0h", ch, wr ? "write" : "read", addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0]  w1;
    logic [3:0]     e4;
    logic [127:0]   ecnt;
    rst = 1'b1;
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_mem_rdata = '0; a_mem_resp = 1'b0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_mem_rdata = '0; b_mem_resp = 1'b0;
    tick();
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_cmd", {a_mem_read, a_mem_write}, 0);
    chk("rst_resp", a_resp, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_addr", a_mem_address, 0);
    chk("rst_wdata", a_mem_wdata, 0);
    chk("rst_cnt", a_cnt, 0);
    rst = 1'b0;

    // mem_resp while idle must not start anything
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    chk("idle_memresp_busy", a_busy, 0);
    chk("idle_memresp_resp", a_resp, 0);

    // single read, ch0, mem_resp after 4 cycles
    a_rd = 2'b01;
    a_addr = {32'h0000_0000, 32'h0000_0100};
    txn2(0, 1'b0, 32'h100, '0, {32{8'hAA}}, 4);
    a_rd = '0;

    // both reading with pointer at 1: ch1 then ch0
    a_rd = 2'b11;
    a_addr = {32'h0000_0200, 32'h0000_0180};
    txn2(1, 1'b0, 32'h200, '0, {32{8'h11}}, 1);
    txn2(0, 1'b0, 32'h180, '0, {32{8'h22}}, 0);
    a_rd = '0;

    // ch1 read+write at 0x240: write first, read afterwards
    w1 = {8{32'hC0FF_EE01}};
    a_rd = 2'b10;
    a_wr = 2'b10;
    a_addr = {32'h0000_0240, 32'h0000_0999};
    a_wdata = {w1, {8{32'h5555_5555}}};
    txn2(1, 1'b1, 32'h240, w1, {32{8'h33}}, 2);
    a_wr = '0;
    txn2(1, 1'b0, 32'h240, '0, {32{8'h44}}, 1);
    a_rd = '0;

    // move pointer to 1, then abort a ch1 read with reset
    a_rd = 2'b01;
    a_addr = {32'h0000_0300, 32'h0000_0280};
    txn2(0, 1'b0, 32'h280, '0, {32{8'h55}}, 0);
    a_rd = 2'b10;
    tick();
    a_rd = '0;
    chk("abort_grant", a_mem_read, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_cmd_drop", {a_mem_read, a_mem_write}, 0);
    chk("abort_busy", a_busy, 0);
    a_mem_resp = 1'b1;
    tick();
    rst = 1'b0;
    a_mem_resp = 1'b0;
    chk("abort_no_resp", a_resp, 0);
    tick();
    chk("abort_no_resp2", a_resp, 0);

    // after reset the pointer is back at 0
    a_rd = 2'b11;
    a_addr = {32'h0000_0440, 32'h0000_0400};
    txn2(0, 1'b0, 32'h400, '0, {32{8'h66}}, 1);
    txn2(1, 1'b0, 32'h440, '0, {32{8'h77}}, 1);
    a_rd = '0;
    chk("cnt_2ch", a_cnt, {32'(PERF), 32'(PERF)});

    // 4 channels requesting continuously: 0,1,2,3,0,1,2,3
    b_rd = 4'hF;
    b_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("rr4_addr", b_mem_address, 32'((g % 4) * 32'h1000));
      b_mem_rdata = {8{32'(g)}};
      b_mem_resp = 1'b1;
      tick();
      b_mem_resp = 1'b0;
      e4 = 4'(1 << (g % 4));
      chk("rr4_resp", b_resp, e4);
      chk("rr4_rdata", b_rdata, {8{32'(g)}});
      $display("txn4 grant=%0d resp=%b", g, b_resp);
      tick();
    end
    b_rd = '0;
    tick();
    ecnt = {4{32'(PERF * 2)}};
    chk("cnt_4ch", b_cnt, ecnt);
    chk("rr4_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
